// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registers one ALU op, waits SETTLE_CYCLES, returns captured result/flags (macro ALU_SLT_FIXUP_EN: SLT issued as SUB with sign fixup)
module alu_cmd_issuer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_selector,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_overflow,
    output logic             rsp_zero
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [7:0] cnt;
    logic [2:0] issue_sel;
    logic [WIDTH-1:0] cap_result;
    logic cap_carry, cap_ovf, accept, capture;
`ifdef ALU_SLT_FIXUP_EN
    logic slt_q;
    always_comb begin
        issue_sel  = (req_op == 3'd3) ? 3'd1 : req_op;
        cap_result = slt_q ? WIDTH'(alu_result[WIDTH-1] ^ alu_overflow) : alu_result;
        cap_carry  = alu_carryout & ~slt_q;
        cap_ovf    = alu_overflow & ~slt_q;
    end
    always_ff @(posedge clk)
        if (reset) slt_q <= 1'b0;
        else if (accept) slt_q <= (req_op == 3'd3);
`else
    always_comb begin
        issue_sel  = req_op;
        cap_result = alu_result;
        cap_carry  = alu_carryout;
        cap_ovf    = alu_overflow;
    end
`endif
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        accept    = req_valid && req_ready;
        capture   = (state == WAIT) && (cnt == 8'd0);
        state_nxt = accept ? WAIT :
                    capture ? RESP :
                    (rsp_valid && rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_selector <= '0;
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            if (accept) begin
                cnt          <= 8'(SETTLE_CYCLES - 1);
                alu_a        <= req_a;
                alu_b        <= req_b;
                alu_selector <= issue_sel;
            end else if (state == WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (capture) begin
                rsp_result   <= cap_result;
                rsp_carryout <= cap_carry;
                rsp_overflow <= cap_ovf;
                rsp_zero     <= (cap_result == '0);
            end
        end
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator side of the 32-bit ALU command interface. It accepts one operation request (operands plus 3-bit command) over a valid/ready handshake and drives registered, stable operands and selector into the gate-level ALU. It then waits a programmable settle time covering the ALU's gate-delay ripple, captures the result and flags, and returns them over a valid/ready response handshake. It sits between the datapath controller and the ALU, and has one operation outstanding at a time.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU (only 32 is supported).
- SETTLE_CYCLES, 4, clock cycles from issue to capture; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  issuer can accept a request.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_op  input  3  command: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_selector  output  3  registered command to the ALU.
- alu_result  input  WIDTH  ALU result.
- alu_carryout  input  1  ALU carry out.
- alu_overflow  input  1  ALU signed overflow.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  WIDTH  captured result.
- rsp_carryout  output  1  captured carry.
- rsp_overflow  output  1  captured overflow.
- rsp_zero  output  1  1 when rsp_result == 0; computed locally from the captured result.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, and alu_a, alu_b, alu_selector, rsp_result, rsp_carryout, rsp_overflow, rsp_zero all 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&&req_ready, register req_a/req_b/req_op into alu_a/alu_b/alu_selector, load settle counter with SETTLE_CYCLES-1, and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge.
  - On the edge where the counter equals 0, capture alu_result/alu_carryout/alu_overflow into rsp_* and compute rsp_zero; go to RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES cycles after the accepting edge. SETTLE_CYCLES=1 captures on the edge after acceptance.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_* held stable until rsp_valid&&rsp_ready at an edge.
  - On handshake: rsp_valid=0, go to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
  - Minimum issue interval: SETTLE_CYCLES+2 cycles.
- alu_a/alu_b/alu_selector only change on an accepting edge (or reset); they hold the last issued values in IDLE and RESP, so no spurious ALU toggling.
- Requests presented while req_ready=0 are ignored; the requester must hold them.
- rsp_* captured fields change only at the capture edge or reset.
- Reset in any state, including mid-WAIT and mid-RESP:
  - Next cycle is IDLE with all outputs at reset values.
  - The in-flight operation is discarded; no response is produced.
- Undefined req_op values cannot occur (3-bit full decode); every code is passed to the ALU unmodified (except SLT with the optional feature).

Optional Feature:
Macro ALU_SLT_FIXUP_EN.
- Defined:
  - On accept with req_op=3 (SLT), the issuer drives alu_selector=1 (SUB) and remembers the SLT flag.
  - At capture: rsp_result = {31'b0, alu_result[31] ^ alu_overflow}; rsp_carryout=0, rsp_overflow=0; rsp_zero follows the fixed-up result.
- Undefined: SLT is issued as selector 3 and the raw ALU result and flags are returned unmodified.
- All other ops are identical in both builds.

Test Plan:
- Reset, then SUB a=0x00000802 b=0x00000001 (SETTLE_CYCLES=4) -> rsp_valid exactly 4 cycles after accept; rsp_result=0x00000801, carryout=1, overflow=0, zero=0.
- ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, overflow=1, carryout=0, zero=0.
- ADD a=0xFFFFFFFF b=0x00000001 -> result 0x00000000, carryout=1, overflow=0, zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 with new operands -> rsp_* stable, req_ready=0, alu_* unchanged; after the handshake, the new request is accepted the following cycle.
- Assert reset 2 cycles into WAIT of AND 0xF0F0F0F0,0xFF00FF00 -> no rsp_valid ever; all outputs 0 the next cycle; a following OR 0x0000000F,0x000000F0 returns 0x000000FF.
- With ALU_SLT_FIXUP_EN: SLT a=0xFFFFFFFB b=0x00000003 -> alu_selector observed =1, rsp_result=0x00000001, zero=0; SLT a=3 b=0xFFFFFFFB -> rsp_result=0, zero=1.
